// File: rtl/series_adder_stream_if.sv
// ----------------------------------------------------------------------------
// series_adder_stream_if
// Bundles the two handshaked streams of the series adder:
//   input stream  : data_i / data_vld / data_rdy        (header + operands)
//   output stream : result_o / result_vld / result_rdy  (sum beats)
//                   result_first / result_last / result_ovf (beat sideband)
// master : the side that feeds operands and consumes result beats
// slave  : the adder itself
// ----------------------------------------------------------------------------
interface series_adder_stream_if #(
    parameter int DATA_W = 32,
    parameter int OUT_W  = 32
);
    logic [DATA_W-1:0] data_i;
    logic              data_vld;
    logic              data_rdy;
    logic [OUT_W-1:0]  result_o;
    logic              result_vld;
    logic              result_rdy;
    logic              result_first;
    logic              result_last;
    logic              result_ovf;

    modport master (
        output data_i, data_vld, result_rdy,
        input  data_rdy, result_o, result_vld, result_first, result_last, result_ovf
    );

    modport slave (
        input  data_i, data_vld, result_rdy,
        output data_rdy, result_o, result_vld, result_first, result_last, result_ovf
    );
endinterface

// File: rtl/series_adder_stream.sv
// ----------------------------------------------------------------------------
// series_adder_stream
// Takes a packet (header word holding operand count N in its low CNT_W bits,
// then N operands) and accumulates the operands into a SUM_W-bit sum with
// sticky overflow detection. The sum leaves as NBEATS = ceil(SUM_W/OUT_W)
// beats, least-significant beat first, with backpressure honoured.
//
// Ports:
//   clk          system clock
//   rst_p        synchronous active-high reset (discards any partial packet)
//   bus          slave side of series_adder_stream_if (input + result streams)
//   module_idle  high while waiting for a header
// ----------------------------------------------------------------------------
module series_adder_stream #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    parameter int SUM_W  = 48,
    parameter int OUT_W  = 32,
    parameter int SIGNED = 0
) (
    input  logic                   clk,
    input  logic                   rst_p,
    series_adder_stream_if.slave   bus,
    output logic                   module_idle
);
    localparam int            NBEATS    = (SUM_W + OUT_W - 1) / OUT_W;
    localparam int            PAD_W     = NBEATS * OUT_W;
    localparam int            BW        = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);
    localparam logic          ONE_BEAT  = (NBEATS == 1);
    localparam logic          IS_SIGNED = (SIGNED != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t             state_r, state_nx_s;
    logic [SUM_W-1:0]   acc_r, acc_nx_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nx_s;
    logic               ovf_r, ovf_nx_s;
    logic [BW-1:0]      beat_r, beat_nx_s;
    logic [OUT_W-1:0]   res_r, res_nx_s;
    logic               res_vld_r, res_vld_nx_s;
    logic               res_first_r, res_first_nx_s;
    logic               res_last_r, res_last_nx_s;
    logic               res_ovf_r, res_ovf_nx_s;

    logic [SUM_W-1:0]   ext_s;
    logic [SUM_W:0]     wide_sum_s;
    logic [SUM_W-1:0]   sum_s;
    logic               add_ovf_s;

    // Widen an input word to SUM_W bits, zero- or sign-filled by mode.
    function automatic logic [SUM_W-1:0] extend_operand(input logic [DATA_W-1:0] w);
        logic                    fill;
        logic [SUM_W+DATA_W-1:0] wide;
        fill = IS_SIGNED & w[DATA_W-1];
        wide = {{SUM_W{fill}}, w};
        return wide[SUM_W-1:0];
    endfunction

    // Select beat idx of the sum; bits above SUM_W in the top beat carry the fill.
    function automatic logic [OUT_W-1:0] beat_of(input logic [SUM_W-1:0] a,
                                                 input logic [BW-1:0]    idx);
        logic                   fill;
        logic [PAD_W+SUM_W-1:0] wide;
        fill = IS_SIGNED & a[SUM_W-1];
        wide = {{PAD_W{fill}}, a};
        return wide[int'(idx)*OUT_W +: OUT_W];
    endfunction

    // Handshake readiness is a pure function of state.
    assign bus.data_rdy     = (state_r != S_OUT);
    assign module_idle      = (state_r == S_IDLE);
    assign bus.result_o     = res_r;
    assign bus.result_vld   = res_vld_r;
    assign bus.result_first = res_first_r;
    assign bus.result_last  = res_last_r;
    assign bus.result_ovf   = res_ovf_r;

    // Add the current input word to the accumulator and flag overflow of this step.
    always_comb begin
        ext_s      = extend_operand(bus.data_i);
        wide_sum_s = {1'b0, acc_r} + {1'b0, ext_s};
        sum_s      = wide_sum_s[SUM_W-1:0];
        if (IS_SIGNED) begin
            // Like-signed addends producing an opposite-signed result.
            add_ovf_s = (acc_r[SUM_W-1] == ext_s[SUM_W-1]) &&
                        (sum_s[SUM_W-1] != acc_r[SUM_W-1]);
        end else begin
            add_ovf_s = wide_sum_s[SUM_W];
        end
    end

    // Next-state and next-output decode; output registers are loaded with the
    // beat that will be presented in the following cycle.
    always_comb begin
        state_nx_s     = state_r;
        acc_nx_s       = acc_r;
        cnt_nx_s       = cnt_r;
        ovf_nx_s       = ovf_r;
        beat_nx_s      = beat_r;
        res_nx_s       = res_r;
        res_vld_nx_s   = res_vld_r;
        res_first_nx_s = res_first_r;
        res_last_nx_s  = res_last_r;
        res_ovf_nx_s   = res_ovf_r;

        case (state_r)
            S_IDLE: begin
                if (bus.data_vld) begin
                    cnt_nx_s = bus.data_i[CNT_W-1:0];
                    acc_nx_s = '0;
                    ovf_nx_s = 1'b0;
                    if (bus.data_i[CNT_W-1:0] == '0) begin
                        // Empty packet: present an all-zero sum right away.
                        state_nx_s     = S_OUT;
                        beat_nx_s      = '0;
                        res_nx_s       = '0;
                        res_vld_nx_s   = 1'b1;
                        res_first_nx_s = 1'b1;
                        res_last_nx_s  = ONE_BEAT;
                        res_ovf_nx_s   = 1'b0;
                    end else begin
                        state_nx_s = S_ACC;
                    end
                end else begin
                    state_nx_s = S_IDLE;
                end
            end

            S_ACC: begin
                if (bus.data_vld) begin
                    acc_nx_s = sum_s;
                    ovf_nx_s = ovf_r | add_ovf_s;
                    cnt_nx_s = cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_nx_s     = S_OUT;
                        beat_nx_s      = '0;
                        res_nx_s       = beat_of(sum_s, BW'(0));
                        res_vld_nx_s   = 1'b1;
                        res_first_nx_s = 1'b1;
                        res_last_nx_s  = ONE_BEAT;
                        res_ovf_nx_s   = ovf_r | add_ovf_s;
                    end else begin
                        state_nx_s = S_ACC;
                    end
                end else begin
                    state_nx_s = S_ACC;
                end
            end

            S_OUT: begin
                if (bus.result_rdy) begin
                    if (beat_r == LAST_BEAT) begin
                        state_nx_s     = S_IDLE;
                        beat_nx_s      = '0;
                        res_nx_s       = '0;
                        res_vld_nx_s   = 1'b0;
                        res_first_nx_s = 1'b0;
                        res_last_nx_s  = 1'b0;
                        res_ovf_nx_s   = 1'b0;
                    end else begin
                        beat_nx_s      = beat_r + BW'(1);
                        res_nx_s       = beat_of(acc_r, beat_r + BW'(1));
                        res_first_nx_s = 1'b0;
                        res_last_nx_s  = ((beat_r + BW'(1)) == LAST_BEAT);
                    end
                end else begin
                    // Backpressure: everything presented stays put.
                    state_nx_s = S_OUT;
                end
            end

            default: begin
                state_nx_s     = S_IDLE;
                beat_nx_s      = '0;
                res_nx_s       = '0;
                res_vld_nx_s   = 1'b0;
                res_first_nx_s = 1'b0;
                res_last_nx_s  = 1'b0;
                res_ovf_nx_s   = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            state_r     <= S_IDLE;
            acc_r       <= '0;
            cnt_r       <= '0;
            ovf_r       <= 1'b0;
            beat_r      <= '0;
            res_r       <= '0;
            res_vld_r   <= 1'b0;
            res_first_r <= 1'b0;
            res_last_r  <= 1'b0;
            res_ovf_r   <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            acc_r       <= acc_nx_s;
            cnt_r       <= cnt_nx_s;
            ovf_r       <= ovf_nx_s;
            beat_r      <= beat_nx_s;
            res_r       <= res_nx_s;
            res_vld_r   <= res_vld_nx_s;
            res_first_r <= res_first_nx_s;
            res_last_r  <= res_last_nx_s;
            res_ovf_r   <= res_ovf_nx_s;
        end
    end
endmodule

// File: tb/tb_series_adder_stream.sv
// ----------------------------------------------------------------------------
// tb_series_adder_stream
// Four adder instances with different configurations:
//   0: SUM_W=48 unsigned   1: SUM_W=32 unsigned
//   2: SUM_W=32 signed     3: SUM_W=48 signed        (DATA_W=OUT_W=32)
// A reference model computes each packet's sum with plain integer arithmetic
// and a range check, and queues the expected beats; a monitor compares every
// valid output beat against that queue. Directed literal checks pin both the
// model and the DUT.
// ----------------------------------------------------------------------------
module tb_series_adder_stream;
    localparam int NI = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        first;
        logic        last;
        logic        ovf;
    } beat_t;

    function automatic int cfg_sumw(input int g);
        return (g == 1 || g == 2) ? 32 : 48;
    endfunction

    function automatic int cfg_signed(input int g);
        return (g >= 2) ? 1 : 0;
    endfunction

    function automatic int cfg_nbeats(input int g);
        return (cfg_sumw(g) + 31) / 32;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0]       rst;
    logic [NI-1:0][31:0] din;
    logic [NI-1:0]       dvld;
    logic [NI-1:0]       drdy;
    logic [NI-1:0][31:0] rdat;
    logic [NI-1:0]       rvld;
    logic [NI-1:0]       rrdy;
    logic [NI-1:0]       rfirst;
    logic [NI-1:0]       rlast;
    logic [NI-1:0]       rovf;
    logic [NI-1:0]       idle;

    beat_t       exp_q [NI][$];
    logic [31:0] cap   [NI][$];
    int          total = 0;
    int          bad   = 0;
    bit          done  = 1'b0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        series_adder_stream_if #(.DATA_W(32), .OUT_W(32)) bus ();
        assign bus.data_i     = din[g];
        assign bus.data_vld   = dvld[g];
        assign bus.result_rdy = rrdy[g];
        assign drdy[g]        = bus.data_rdy;
        assign rdat[g]        = bus.result_o;
        assign rvld[g]        = bus.result_vld;
        assign rfirst[g]      = bus.result_first;
        assign rlast[g]       = bus.result_last;
        assign rovf[g]        = bus.result_ovf;

        series_adder_stream #(
            .DATA_W(32), .CNT_W(16), .SUM_W(cfg_sumw(g)), .OUT_W(32), .SIGNED(cfg_signed(g))
        ) dut (
            .clk        (clk),
            .rst_p      (rst[g]),
            .bus        (bus),
            .module_idle(idle[g])
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact integer sum, wrapped back into range whenever a step leaves it.
    function automatic void model_packet(input int k, input int n, input logic [31:0] w [4],
                                         output longint val, output bit ovf);
        longint span, lo, hi, op;
        span = longint'(1) << cfg_sumw(k);
        if (cfg_signed(k) != 0) begin
            lo = -(span / 2);
            hi = span / 2 - 1;
        end else begin
            lo = 0;
            hi = span - 1;
        end
        val = 0;
        ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (cfg_signed(k) != 0) op = longint'($signed(w[i]));
            else                    op = longint'({32'd0, w[i]});
            val = val + op;
            if (val > hi) begin
                ovf = 1'b1;
                val = val - span;
            end else if (val < lo) begin
                ovf = 1'b1;
                val = val + span;
            end
        end
    endfunction

    task automatic send_word(input int k, input logic [31:0] w, input bit is_last);
        int waited = 0;
        din[k]  = w;
        dvld[k] = 1'b1;
        @(negedge clk);
        while (!drdy[k] && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("rdy_wait%0d", k), 64'(drdy[k]), 64'd1);
        @(posedge clk);
        #1;
        dvld[k] = 1'b0;
        if (is_last) begin
            check($sformatf("latency_vld%0d", k), 64'(rvld[k]), 64'd1);
            check($sformatf("latency_first%0d", k), 64'(rfirst[k]), 64'd1);
        end
    endtask

    task automatic send_packet(input int k, input int n, input logic [31:0] w0,
                               input logic [31:0] w1, input logic [31:0] w2,
                               input logic [31:0] w3, input int gap);
        logic [31:0] w [4];
        longint      val;
        bit          ovf;
        logic [63:0] v;
        beat_t       e;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        model_packet(k, n, w, val, ovf);
        v = val;
        for (int b = 0; b < cfg_nbeats(k); b++) begin
            e.data  = v[b*32 +: 32];
            e.first = (b == 0);
            e.last  = (b == cfg_nbeats(k) - 1);
            e.ovf   = ovf;
            exp_q[k].push_back(e);
        end
        send_word(k, 32'(n), n == 0);
        for (int i = 0; i < n; i++) begin
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            send_word(k, w[i], i == n - 1);
        end
    endtask

    task automatic drain(input int k);
        int c = 0;
        while (exp_q[k].size() != 0 && c < 200) begin
            @(posedge clk);
            c++;
        end
        #1;
        check($sformatf("drain%0d", k), 64'(exp_q[k].size()), 64'd0);
        check($sformatf("idle_after%0d", k), 64'(idle[k]), 64'd1);
    endtask

    task automatic check_cap(input int k, input string name, input int n,
                             input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        check({name, "_count"}, 64'(cap[k].size()), 64'(n));
        for (int i = 0; i < n && i < cap[k].size(); i++)
            check($sformatf("%s_beat%0d", name, i), 64'(cap[k][i]), 64'(e[i]));
        cap[k].delete();
    endtask

    initial begin
        logic [31:0] pw [4];
        longint      pval;
        bit          povf;

        rst  = '1;
        din  = '0;
        dvld = '0;
        rrdy = '1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_idle%0d", k),  64'(idle[k]),   64'd1);
            check($sformatf("rst_rdy%0d", k),   64'(drdy[k]),   64'd1);
            check($sformatf("rst_vld%0d", k),   64'(rvld[k]),   64'd0);
            check($sformatf("rst_first%0d", k), 64'(rfirst[k]), 64'd0);
            check($sformatf("rst_last%0d", k),  64'(rlast[k]),  64'd0);
            check($sformatf("rst_ovf%0d", k),   64'(rovf[k]),   64'd0);
            check($sformatf("rst_data%0d", k),  64'(rdat[k]),   64'd0);
        end
        rst = '0;

        // Pin the model against hand-computed sums.
        pw[0] = 32'h1; pw[1] = 32'h2; pw[2] = 32'h3; pw[3] = 32'h0;
        model_packet(0, 3, pw, pval, povf);
        check("model_sum_123", 64'(pval), 64'd6);
        pw[0] = 32'hFFFF_FFFF; pw[1] = 32'h1;
        model_packet(1, 2, pw, pval, povf);
        check("model_u32_wrap", 64'(pval), 64'd0);
        check("model_u32_ovf", 64'(povf), 64'd1);
        pw[0] = 32'hFFFF_FFFE; pw[1] = 32'h1;
        model_packet(3, 2, pw, pval, povf);
        check("model_s48_neg", 64'(pval), 64'hFFFF_FFFF_FFFF_FFFF);

        fork
            begin
                while (!done) begin
                    @(negedge clk);
                    for (int k = 0; k < NI; k++) begin
                        if (!rst[k] && rvld[k]) begin
                            check($sformatf("beat_expected%0d", k), 64'(exp_q[k].size() > 0), 64'd1);
                            if (exp_q[k].size() > 0) begin
                                check($sformatf("data%0d", k),  64'(rdat[k]),   64'(exp_q[k][0].data));
                                check($sformatf("first%0d", k), 64'(rfirst[k]), 64'(exp_q[k][0].first));
                                check($sformatf("last%0d", k),  64'(rlast[k]),  64'(exp_q[k][0].last));
                                check($sformatf("ovf%0d", k),   64'(rovf[k]),   64'(exp_q[k][0].ovf));
                                check($sformatf("out_rdy%0d", k), 64'(drdy[k]), 64'd0);
                                if (rrdy[k]) begin
                                    cap[k].push_back(rdat[k]);
                                    void'(exp_q[k].pop_front());
                                end
                            end
                        end
                    end
                end
            end
            begin
                // Basic three-operand sum, two beats.
                send_packet(0, 3, 32'h1, 32'h2, 32'h3, 32'h0, 0);
                drain(0);
                check_cap(0, "sum123", 2, 32'h6, 32'h0, 32'h0, 32'h0);

                // Carry into the second beat, with input gaps.
                send_packet(0, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 2);
                drain(0);
                check_cap(0, "carry", 2, 32'hFFFF_FFFE, 32'h1, 32'h0, 32'h0);

                // Single-beat configurations with overflow.
                send_packet(1, 2, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 0);
                drain(1);
                check_cap(1, "u32ovf", 1, 32'h0, 32'h0, 32'h0, 32'h0);
                send_packet(2, 2, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0, 0);
                drain(2);
                check_cap(2, "s32ovf", 1, 32'h8000_0000, 32'h0, 32'h0, 32'h0);

                // Signed 48-bit negative result, sign-extended top beat.
                send_packet(3, 2, 32'hFFFF_FFFE, 32'h1, 32'h0, 32'h0, 0);
                drain(3);
                check_cap(3, "s48neg", 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);

                // Empty packet followed immediately by N=1.
                send_packet(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
                send_packet(0, 1, 32'h5, 32'h0, 32'h0, 32'h0, 0);
                drain(0);
                check_cap(0, "b2b", 4, 32'h0, 32'h0, 32'h5, 32'h0);

                // Backpressure on the first beat.
                rrdy[0] = 1'b0;
                send_packet(0, 2, 32'd10, 32'd20, 32'h0, 32'h0, 0);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check($sformatf("bp_data_c%0d", i),  64'(rdat[0]),   64'd30);
                    check($sformatf("bp_vld_c%0d", i),   64'(rvld[0]),   64'd1);
                    check($sformatf("bp_first_c%0d", i), 64'(rfirst[0]), 64'd1);
                    check($sformatf("bp_rdy_c%0d", i),   64'(drdy[0]),   64'd0);
                end
                @(posedge clk);
                #1;
                rrdy[0] = 1'b1;
                drain(0);
                check_cap(0, "bp", 2, 32'd30, 32'h0, 32'h0, 32'h0);

                // Reset after 2 of 4 operands discards the partial packet.
                send_word(0, 32'd4, 1'b0);
                send_word(0, 32'h1, 1'b0);
                send_word(0, 32'h2, 1'b0);
                check("mid_pkt_busy", 64'(idle[0]), 64'd0);
                rst[0] = 1'b1;
                @(posedge clk);
                #1;
                check("mid_rst_idle", 64'(idle[0]), 64'd1);
                check("mid_rst_rdy",  64'(drdy[0]), 64'd1);
                check("mid_rst_vld",  64'(rvld[0]), 64'd0);
                check("mid_rst_data", 64'(rdat[0]), 64'd0);
                rst[0] = 1'b0;
                send_packet(0, 1, 32'h7, 32'h0, 32'h0, 32'h0, 0);
                drain(0);
                check_cap(0, "after_rst", 2, 32'h7, 32'h0, 32'h0, 32'h0);

                done = 1'b1;
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
